// File: rtl/clock_time_controller.sv
// clock_time_controller: hours/minutes/seconds keeper with a RUN / SET_HOUR /
// SET_MIN mode FSM. It sits between the tick counter and the display decoder.
// Optional build macro HOUR12_EN selects the 12-hour format with a PM flag.
// Without it the clock runs 0..23 and pm is tied low.
module clock_time_controller #(
    parameter int HOURS_INIT   = 0,
    parameter int MINUTES_INIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] mode,
    output logic       tick_clr,
    output logic       pm
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_t;

    localparam logic [4:0] H_INIT = 5'(HOURS_INIT);
    localparam logic [5:0] M_INIT = 6'(MINUTES_INIT);

    state_t state;

    // The state register is the mode output, so mode needs no extra flop.
    assign mode = state;

    // Every field compares against its maximum before it is incremented,
    // so no arithmetic overflow is relied upon.
    function automatic logic [4:0] hour_next(input logic [4:0] h);
`ifdef HOUR12_EN
        return (h == 5'd12) ? 5'd1 : h + 5'd1;
`else
        return (h == 5'd23) ? 5'd0 : h + 5'd1;
`endif
    endfunction

    function automatic logic [5:0] sixty_next(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

`ifndef HOUR12_EN
    assign pm = 1'b0;
`endif

    // Mode FSM, timekeeping and the tick-counter clear pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            hours    <= H_INIT;
            minutes  <= M_INIT;
            seconds  <= 6'd0;
            tick_clr <= 1'b0;
`ifdef HOUR12_EN
            pm       <= 1'b0;
`endif
        end else begin
            tick_clr <= 1'b0;
            case (state)
                RUN: begin
                    // A tick in the same cycle as btn_mode is still applied.
                    if (tick) begin
                        seconds <= sixty_next(seconds);
                        if (seconds == 6'd59) begin
                            minutes <= sixty_next(minutes);
                            if (minutes == 6'd59) begin
                                hours <= hour_next(hours);
`ifdef HOUR12_EN
                                if (hours == 5'd11) pm <= ~pm;
`endif
                            end
                        end
                    end
                    if (btn_mode) state <= SET_HOUR;
                end
                SET_HOUR: begin
                    if (btn_mode) begin
                        state <= SET_MIN;
                    end else if (btn_inc) begin
                        hours <= hour_next(hours);
`ifdef HOUR12_EN
                        if (hours == 5'd11) pm <= ~pm;
`endif
                    end
                end
                SET_MIN: begin
                    // Leaving set mode restarts the second phase from zero.
                    // Any tick that arrives on this edge is discarded.
                    if (btn_mode) begin
                        state    <= RUN;
                        seconds  <= 6'd0;
                        tick_clr <= 1'b1;
                    end else if (btn_inc) begin
                        minutes <= sixty_next(minutes);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_time_controller.sv
// Directed testbench for clock_time_controller (HOURS_INIT=9, MINUTES_INIT=30).
// When HOUR12_EN is defined, the 12-hour carry and pm sequence is exercised
// instead of the 24-hour sequence.
module tb_clock_time_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       tick_clr;
    logic       pm;

    int tests = 0;
    int failed = 0;
    int clr_cnt = 0;

    clock_time_controller #(.HOURS_INIT(9), .MINUTES_INIT(30)) dut (
        .clk(clk), .rst(rst), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .hours(hours), .minutes(minutes), .seconds(seconds), .mode(mode),
        .tick_clr(tick_clr), .pm(pm)
    );

    always #10 clk = ~clk;

    // Count the cycles in which tick_clr is high.
    always @(negedge clk) if (tick_clr) clr_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s, input int md);
        chk({tag, ".hours"}, 32'(hours), 32'(h));
        chk({tag, ".minutes"}, 32'(minutes), 32'(m));
        chk({tag, ".seconds"}, 32'(seconds), 32'(s));
        chk({tag, ".mode"}, 32'(mode), 32'(md));
    endtask

    // Drive one cycle of inputs, clock it in, and return 1 time unit after the edge.
    task automatic cyc(input logic t, input logic m, input logic i);
        tick = t; btn_mode = m; btn_inc = i;
        @(posedge clk); #1;
        tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic incs(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_time("reset", 9, 30, 0, 0);
        chk("reset.tick_clr", 32'(tick_clr), 0);
        chk("reset.pm", 32'(pm), 0);
        rst = 1'b0;

        // Five ticks in RUN; btn_inc is ignored in RUN
        ticks(5);
        chk_time("run5", 9, 30, 5, 0);
        cyc(1'b0, 1'b0, 1'b1);
        chk_time("run_inc_ignored", 9, 30, 5, 0);
        chk("run.clr_cnt", 32'(clr_cnt), 0);

`ifndef HOUR12_EN
        // Set the time to 23:59, then run up to 23:59:58
        cyc(1'b0, 1'b1, 1'b0);
        chk("to_set_hour.mode", 32'(mode), 1);
        incs(14);
        chk("hours_23", 32'(hours), 23);
        cyc(1'b0, 1'b1, 1'b0);
        chk("to_set_min.mode", 32'(mode), 2);
        incs(29);
        chk("minutes_59", 32'(minutes), 59);
        cyc(1'b0, 1'b1, 1'b0);
        chk_time("exit1", 23, 59, 0, 0);
        chk("exit1.tick_clr", 32'(tick_clr), 1);
        ticks(58);
        chk_time("pre_roll", 23, 59, 58, 0);
        chk("pre_roll.clr_cnt", 32'(clr_cnt), 1);
        cyc(1'b1, 1'b0, 1'b0);
        chk_time("roll_a", 23, 59, 59, 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk_time("roll_b", 0, 0, 0, 0);

        // SET_HOUR with ticks interleaved: time stays frozen
        ticks(17);
        chk_time("sec17", 0, 0, 17, 0);
        cyc(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 1'b1);
            cyc(1'b1, 1'b0, 1'b0);
        end
        chk_time("set_hour3", 3, 0, 17, 1);
        cyc(1'b0, 1'b1, 1'b0);
        incs(61);
        chk_time("set_min61", 3, 1, 17, 2);

        // Exit coinciding with a tick: the tick is dropped and tick_clr pulses once
        cyc(1'b1, 1'b1, 1'b0);
        chk_time("exit2", 3, 1, 0, 0);
        chk("exit2.tick_clr", 32'(tick_clr), 1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("exit2.tick_clr_low", 32'(tick_clr), 0);
        chk("exit2.clr_cnt", 32'(clr_cnt), 2);
        cyc(1'b1, 1'b0, 1'b0);
        chk_time("resume", 3, 1, 1, 0);

        // tick and btn_mode together in RUN: the tick applies and the mode advances
        cyc(1'b1, 1'b1, 1'b0);
        chk_time("tick_mode", 3, 1, 2, 1);

        // btn_mode and btn_inc together: mode wins
        cyc(1'b0, 1'b1, 1'b1);
        chk_time("mode_wins", 3, 1, 2, 2);
        cyc(1'b0, 1'b0, 1'b1);
        chk_time("min_inc", 3, 2, 2, 2);

        // Asynchronous reset in SET_MIN
        #3;
        rst = 1'b1;
        #1;
        chk_time("async_rst", 9, 30, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("final.clr_cnt", 32'(clr_cnt), 2);
        chk("final.pm", 32'(pm), 0);
`else
        // 12-hour mode: 11:59:59 -> 12:00:00 sets pm
        cyc(1'b0, 1'b1, 1'b0);
        incs(2);
        chk("h12.hours11", 32'(hours), 11);
        chk("h12.pm0", 32'(pm), 0);
        cyc(1'b0, 1'b1, 1'b0);
        incs(29);
        cyc(1'b0, 1'b1, 1'b0);
        ticks(59);
        chk_time("h12.pre", 11, 59, 59, 0);
        chk("h12.pre.pm", 32'(pm), 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk_time("h12.noon", 12, 0, 0, 0);
        chk("h12.noon.pm", 32'(pm), 1);

        // 12:59:59 -> 01:00:00 leaves pm set
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        incs(59);
        cyc(1'b0, 1'b1, 1'b0);
        ticks(59);
        chk_time("h12.pre1", 12, 59, 59, 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk_time("h12.one", 1, 0, 0, 0);
        chk("h12.one.pm", 32'(pm), 1);
        chk("h12.clr_cnt", 32'(clr_cnt), 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/clock_time_controller.md
Name: clock_time_controller

Overview:
- Sequencing controller for the wall-clock datapath. Consumes the 1 Hz one-cycle `tick` pulse from the tick counter and keeps hours/minutes/seconds.
- Runs a small mode FSM driven by two pre-debounced button pulses, so the user can stop the clock and set hours and minutes.
- Drives a clear pulse back to the tick counter so the seconds phase restarts cleanly after setting.
- Sits between the tick counter and the display/segment decoder.

Parameters:
- HOURS_INIT, 0, hour value loaded on reset (0..23; 1..12 when HOUR12_EN is defined).
- MINUTES_INIT, 0, minute value loaded on reset (0..59).

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  asynchronous active-high reset
- tick  input  1  one-cycle pulse, one per second, from the tick counter
- btn_mode  input  1  one-cycle pulse; advances the mode FSM
- btn_inc  input  1  one-cycle pulse; increments the selected field in set modes
- hours  output  5  current hour, binary
- minutes  output  6  current minute, binary
- seconds  output  6  current second, binary
- mode  output  2  0=RUN, 1=SET_HOUR, 2=SET_MIN (3 never driven)
- tick_clr  output  1  one-cycle pulse to clear the tick counter phase
- pm  output  1  PM flag; constant 0 unless HOUR12_EN is defined

Behaviour:
- All outputs are registered. On rst: hours=HOURS_INIT, minutes=MINUTES_INIT, seconds=0, mode=RUN, tick_clr=0, pm=0. Reset acts immediately, mid-operation included.
- FSM states: RUN, SET_HOUR, SET_MIN.
  - btn_mode moves RUN->SET_HOUR, SET_HOUR->SET_MIN, SET_MIN->RUN.
  - Each transition takes effect on the clock edge after the pulse; `mode` reflects it one cycle after btn_mode is sampled.
- RUN:
  - Each tick increments seconds by 1.
  - seconds 59->0 carries +1 to minutes.
  - minutes 59->0 carries +1 to hours.
  - hours 23->0.
  - Full rollover 23:59:59 -> 00:00:00 completes in one edge.
  - btn_inc is ignored.
- SET_HOUR / SET_MIN:
  - tick is ignored; time is frozen and seconds holds its value.
  - btn_inc increments only the selected field, with no carry: hours 23->0, minutes 59->0.
- Exit SET_MIN->RUN:
  - seconds is forced to 0 on the same edge.
  - tick_clr is high for exactly one cycle, on the cycle after the transition edge.
  - tick_clr is never asserted at any other time.
- Simultaneous events:
  - btn_mode and btn_inc in the same cycle: mode wins, inc is dropped.
  - tick and btn_mode in the same RUN cycle: the tick is applied (including carries) and the state moves to SET_HOUR on the same edge.
  - tick coinciding with the SET_MIN->RUN exit: the tick is discarded and seconds=0.
- Width rules: all increments are compare-to-max then load 0; no arithmetic overflow is relied upon.
- Latency: tick to updated time is 1 clock. btn_inc to updated field is 1 clock.

Optional Feature:
- Macro: HOUR12_EN.
- Defined:
  - hours ranges 1..12; reset value is HOURS_INIT (which must be 1..12), with pm=0.
  - RUN carry: 11->12 toggles pm; 12->1 leaves pm unchanged.
  - SET_HOUR inc: 12->1, pm unchanged; 11->12 toggles pm.
- Undefined:
  - 24-hour behaviour as above; pm is tied to 0 and has no flops.

Test Plan:
1. Reset with HOURS_INIT=9, MINUTES_INIT=30, then 5 ticks -> 09:30:05, mode=0, tick_clr never asserted.
2. Preload 23:59:58 in RUN, 2 ticks -> 23:59:59, then 00:00:00 on the second tick edge; no intermediate values.
3. btn_mode, then 3x btn_inc with ticks interleaved -> mode=1, hours 0->3, minutes and seconds frozen. btn_mode, then 61x btn_inc -> minutes wraps to 1, hours still 3.
4. From SET_MIN with seconds=17, pulse btn_mode together with tick -> mode=0, seconds=0, tick_clr high exactly 1 cycle after the edge.
5. btn_mode and btn_inc in the same cycle in SET_HOUR -> mode=2, hours unchanged. Assert rst mid-SET_MIN -> immediate return to HOURS_INIT:MINUTES_INIT:00, mode=0.
6. HOUR12_EN defined, start 11:59:59 pm=0, 1 tick -> 12:00:00 pm=1. Preload 12:59:59, 1 tick -> 01:00:00 pm=1.
